level_control: RTL and testbench

Game-progress stage directly downstream of the point-collection block. It consumes the 5-bit `captured` vector and keeps the running score. It detects level completion, holds a level-complete interval, and then advances `lvl`, which feeds back to the collection block. Before each level it issues a one-cycle clear so the collection block starts with an empty `captured` register.

---
 rtl/level_control_if.sv | 22 ++
 rtl/level_control.sv | 149 ++++++++++++++
 tb/tb_level_control.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/level_control_if.sv
// Link between the point-collection block and the level controller.
// The controller side uses the slave modport; the collection side uses master.
interface level_control_if;
    logic       start;
    logic [4:0] captured;
    logic [2:0] lvl;
    logic [11:0] score;
    logic       points_clr;
    logic       new_point;
    logic       level_done;
    logic       game_won;

    modport master (
        output start, captured,
        input  lvl, score, points_clr, new_point, level_done, game_won
    );

    modport slave (
        input  start, captured,
        output lvl, score, points_clr, new_point, level_done, game_won
    );
endinterface

// File: rtl/level_control.sv
// Game-progress controller: scores newly captured points, holds a level-complete
// interval, advances the level and clears the collection block before each level.
module level_control #(
    parameter int DONE_HOLD = 65_000_000,
    parameter int NUM_LVLS  = 3,
    parameter int POINT_VAL = 10
) (
    input logic            clk,
    input logic            rst_n,
    level_control_if.slave bus
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_WON   = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [2:0]  lvl_q, lvl_d;
    logic [11:0] score_q, score_d;
    logic [4:0]  cap_q, cap_d;
    logic [31:0] cnt_q, cnt_d;
    logic        points_clr_q, points_clr_d;
    logic        new_point_q, new_point_d;
    logic        level_done_q, level_done_d;
    logic        game_won_q, game_won_d;

    logic [4:0]  new_bits;
    logic [2:0]  new_count;
    logic [31:0] inc_full;
    logic [11:0] inc_clamped;
    logic [12:0] score_sum;
    logic [11:0] score_sat;

    function automatic logic [2:0] popcount5(input logic [4:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < 5; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

    // The increment is clamped before the 13-bit add so the sum can never wrap.
    assign new_bits    = bus.captured & ~cap_q;
    assign new_count   = popcount5(new_bits);
    assign inc_full    = 32'(new_count) * 32'(POINT_VAL);
    assign inc_clamped = (inc_full > 32'd4095) ? 12'hFFF : inc_full[11:0];
    assign score_sum   = {1'b0, score_q} + {1'b0, inc_clamped};
    assign score_sat   = score_sum[12] ? 12'hFFF : score_sum[11:0];

    always_comb begin
        state_d      = state_q;
        lvl_d        = lvl_q;
        score_d      = score_q;
        cap_d        = cap_q;
        cnt_d        = cnt_q;
        points_clr_d = 1'b0;
        new_point_d  = 1'b0;
        level_done_d = level_done_q;
        game_won_d   = game_won_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d      = ST_CLEAR;
                    lvl_d        = 3'd1;
                    score_d      = '0;
                    points_clr_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                cap_d   = '0;
                state_d = ST_PLAY;
            end
            ST_PLAY: begin
                cap_d = bus.captured;
                if (new_bits != 5'd0) begin
                    score_d     = score_sat;
                    new_point_d = 1'b1;
                end
                if (bus.captured == 5'b11111) begin
                    state_d      = ST_HOLD;
                    level_done_d = 1'b1;
                    cnt_d        = '0;
                end
            end
            ST_HOLD: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == 32'(DONE_HOLD - 1)) begin
                    level_done_d = 1'b0;
                    if (lvl_q == 3'(NUM_LVLS)) begin
                        state_d    = ST_WON;
                        game_won_d = 1'b1;
                    end else begin
                        state_d      = ST_CLEAR;
                        lvl_d        = lvl_q + 3'd1;
                        points_clr_d = 1'b1;
                    end
                end
            end
            ST_WON: begin
                if (bus.start) begin
                    state_d      = ST_CLEAR;
                    game_won_d   = 1'b0;
                    lvl_d        = 3'd1;
                    score_d      = '0;
                    points_clr_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            lvl_q        <= '0;
            score_q      <= '0;
            cap_q        <= '0;
            cnt_q        <= '0;
            points_clr_q <= 1'b0;
            new_point_q  <= 1'b0;
            level_done_q <= 1'b0;
            game_won_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lvl_q        <= lvl_d;
            score_q      <= score_d;
            cap_q        <= cap_d;
            cnt_q        <= cnt_d;
            points_clr_q <= points_clr_d;
            new_point_q  <= new_point_d;
            level_done_q <= level_done_d;
            game_won_q   <= game_won_d;
        end
    end

    assign bus.lvl        = lvl_q;
    assign bus.score      = score_q;
    assign bus.points_clr = points_clr_q;
    assign bus.new_point  = new_point_q;
    assign bus.level_done = level_done_q;
    assign bus.game_won   = game_won_q;

endmodule

// File: tb/tb_level_control.sv
// Scoreboard bench for level_control: stimulus pushes per-cycle expectations,
// a monitor pops and compares them just after each rising edge.
module tb_level_control;

    typedef struct {
        bit          sel;
        logic [2:0]  lvl;
        logic [11:0] score;
        logic        pc;
        logic        np;
        logic        ld;
        logic        gw;
        string       name;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    level_control_if bus_main ();
    level_control_if bus_sat ();

    level_control #(.DONE_HOLD(4), .NUM_LVLS(3), .POINT_VAL(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_main)
    );

    level_control #(.DONE_HOLD(4), .NUM_LVLS(3), .POINT_VAL(1000)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input exp_t e);
        logic [2:0]  a_lvl;
        logic [11:0] a_score;
        logic        a_pc, a_np, a_ld, a_gw;
        if (e.sel) begin
            a_lvl = bus_sat.lvl;   a_score = bus_sat.score; a_pc = bus_sat.points_clr;
            a_np = bus_sat.new_point; a_ld = bus_sat.level_done; a_gw = bus_sat.game_won;
        end else begin
            a_lvl = bus_main.lvl;  a_score = bus_main.score; a_pc = bus_main.points_clr;
            a_np = bus_main.new_point; a_ld = bus_main.level_done; a_gw = bus_main.game_won;
        end
        checks++;
        if (a_lvl !== e.lvl || a_score !== e.score || a_pc !== e.pc ||
            a_np !== e.np || a_ld !== e.ld || a_gw !== e.gw) begin
            failures++;
            $display("[TB] FAIL %s: got lvl=%0d score=%0d clr=%0b np=%0b done=%0b won=%0b, want lvl=%0d score=%0d clr=%0b np=%0b done=%0b won=%0b",
                     e.name, a_lvl, a_score, a_pc, a_np, a_ld, a_gw,
                     e.lvl, e.score, e.pc, e.np, e.ld, e.gw);
        end
    endtask

    function automatic exp_t mk(input bit sel, input int lvl, input int score, input bit pc,
                                input bit np, input bit ld, input bit gw, input string name);
        exp_t e;
        e.sel = sel; e.lvl = 3'(lvl); e.score = 12'(score);
        e.pc = pc; e.np = np; e.ld = ld; e.gw = gw; e.name = name;
        return e;
    endfunction

    // One cycle: drive inputs at the falling edge and queue what the next rising edge must produce.
    task automatic applyStimulus(input bit st, input logic [4:0] cap, input bit sel, input int lvl,
                                 input int score, input bit pc, input bit np, input bit ld,
                                 input bit gw, input string name);
        @(negedge clk);
        bus_main.start = st; bus_main.captured = cap;
        bus_sat.start  = st; bus_sat.captured  = cap;
        exp_q.push_back(mk(sel, lvl, score, pc, np, ld, gw, name));
    endtask

    task automatic assertReset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
    endtask

    task automatic releaseReset();
        @(negedge clk);
        bus_main.start = 1'b0; bus_sat.start = 1'b0;
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no end of run, want finish before 100000 ns");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        bus_main.start = 1'b0; bus_main.captured = 5'b0;
        bus_sat.start  = 1'b0; bus_sat.captured  = 5'b0;
        #12;
        checkOutput(mk(0, 0, 0, 0, 0, 0, 0, "reset_state"));
        releaseReset();

        $display("[TB] start, first capture, then reset mid-play");
        applyStimulus(1, 5'b00000, 0, 1, 0,  1, 0, 0, 0, "a_start");
        applyStimulus(0, 5'b00000, 0, 1, 0,  0, 0, 0, 0, "a_play");
        applyStimulus(0, 5'b00001, 0, 1, 10, 0, 1, 0, 0, "a_capture");
        assertReset();
        checkOutput(mk(0, 0, 0, 0, 0, 0, 0, "async_reset_play"));
        releaseReset();
        applyStimulus(0, 5'b00001, 0, 0, 0, 0, 0, 0, 0, "idle_ignore_1");
        applyStimulus(0, 5'b00001, 0, 0, 0, 0, 0, 0, 0, "idle_ignore_2");

        $display("[TB] level 1: single and simultaneous captures");
        applyStimulus(1, 5'b00000, 0, 1, 0,  1, 0, 0, 0, "start_clear");
        applyStimulus(0, 5'b00000, 0, 1, 0,  0, 0, 0, 0, "clear_one_cycle");
        applyStimulus(0, 5'b00001, 0, 1, 10, 0, 1, 0, 0, "single_cap");
        applyStimulus(0, 5'b00001, 0, 1, 10, 0, 0, 0, 0, "single_pulse_end");
        applyStimulus(0, 5'b00111, 0, 1, 30, 0, 1, 0, 0, "double_cap");
        applyStimulus(0, 5'b00111, 0, 1, 30, 0, 0, 0, 0, "double_pulse_end");
        applyStimulus(0, 5'b11111, 0, 1, 50, 0, 1, 1, 0, "l1_full");
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 5'b11111, 0, 1, 50, 0, 0, 1, 0, "l1_hold");
        applyStimulus(0, 5'b11111, 0, 2, 50, 1, 0, 0, 0, "l2_clear");
        applyStimulus(0, 5'b11111, 0, 2, 50, 0, 0, 0, 0, "l2_stale_not_scored");
        applyStimulus(0, 5'b00000, 0, 2, 50, 0, 0, 0, 0, "l2_play");

        $display("[TB] levels 2 and 3, win and restart");
        applyStimulus(0, 5'b11111, 0, 2, 100, 0, 1, 1, 0, "l2_full");
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 5'b11111, 0, 2, 100, 0, 0, 1, 0, "l2_hold");
        applyStimulus(0, 5'b11111, 0, 3, 100, 1, 0, 0, 0, "l3_clear");
        applyStimulus(0, 5'b11111, 0, 3, 100, 0, 0, 0, 0, "l3_stale");
        applyStimulus(0, 5'b11111, 0, 3, 150, 0, 1, 1, 0, "l3_full");
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 5'b11111, 0, 3, 150, 0, 0, 1, 0, "l3_hold");
        applyStimulus(0, 5'b00000, 0, 3, 150, 0, 0, 0, 1, "won");
        applyStimulus(0, 5'b11111, 0, 3, 150, 0, 0, 0, 1, "won_hold");
        applyStimulus(1, 5'b00000, 0, 1, 0,   1, 0, 0, 0, "restart");
        applyStimulus(0, 5'b00000, 0, 1, 0,   0, 0, 0, 0, "restart_play");

        $display("[TB] saturation and reset during hold");
        assertReset();
        checkOutput(mk(1, 0, 0, 0, 0, 0, 0, "sat_reset"));
        releaseReset();
        applyStimulus(1, 5'b00000, 1, 1, 0,    1, 0, 0, 0, "sat_start");
        applyStimulus(0, 5'b00000, 1, 1, 0,    0, 0, 0, 0, "sat_play");
        applyStimulus(0, 5'b11111, 1, 1, 4095, 0, 1, 1, 0, "sat_full");
        applyStimulus(0, 5'b11111, 1, 1, 4095, 0, 0, 1, 0, "sat_hold");
        assertReset();
        checkOutput(mk(1, 0, 0, 0, 0, 0, 0, "async_reset_hold"));
        checkOutput(mk(0, 0, 0, 0, 0, 0, 0, "async_reset_main"));

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
